// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: FSM encoding, byte width and header helpers shared by the UART-side blocks
package uart_arb_pkg;
    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] HEADER_BASE_DEF = 8'hF0;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;
    function automatic logic [BYTE_W-1:0] hdr_byte(input logic [BYTE_W-1:0] base, input logic [2:0] id);
        return base | {{(BYTE_W-3){1'b0}}, id};
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams, TXMOD byte port and arbiter status
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_last;
    logic [N_REQ-1:0] req_ready;
    logic [uart_arb_pkg::BYTE_W*N_REQ-1:0] req_data;
    logic [uart_arb_pkg::BYTE_W-1:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic [N_REQ-1:0] grant;
    logic timeout;
    modport master(output req_valid, req_data, req_last, tx_ready,
                   input req_ready, tx_data, tx_valid, grant, timeout);
    modport slave(input req_valid, req_data, req_last, tx_ready,
                  output req_ready, tx_data, tx_valid, grant, timeout);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin picker, searching from last+1 with wrap
module rr_priority_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    // walk from farthest to nearest so the nearest requester overwrites
    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                grant = N'(1) << ((int'(last) + k) % N);
                idx = $clog2(N)'((int'(last) + k) % N);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one TXMOD byte port
// with optional channel-ID header and idle-lock timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int                 N_REQ        = 4,
    parameter logic               HEADER_EN    = 1'b1,
    parameter logic [BYTE_W-1:0]  HEADER_BASE  = HEADER_BASE_DEF,
    parameter int                 LOCK_TIMEOUT = 4096
) (
    input logic clk,
    input logic rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = LOCK_TIMEOUT > 0 ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(LOCK_TIMEOUT);
    logic [1:0] state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d, pick_grant, req_ready;
    logic [IW-1:0] sel_q, sel_d, pick_idx;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d, req_byte;
    logic tx_valid_q, tx_valid_d, timeout_q, timeout_d;
    logic [CW-1:0] idle_q, idle_d;
    logic pick_any, accept, own_valid;
    rr_priority_pick #(.N(N_REQ)) u_pick (
        .req(bus.req_valid), .last(sel_q), .grant(pick_grant), .idx(pick_idx), .any(pick_any)
    );
    // sel_q doubles as last_grant: it keeps the previous owner while IDLE
    assign own_valid = bus.req_valid[sel_q];
    assign req_byte = bus.req_data[int'(sel_q)*BYTE_W +: BYTE_W];
    assign req_ready = (state_q == ST_DATA && (!tx_valid_q || bus.tx_ready)) ? grant_q : '0;
    assign accept = |(req_ready & bus.req_valid);
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d = sel_q;
        tx_valid_d = tx_valid_q & ~bus.tx_ready;
        tx_data_d = tx_data_q;
        timeout_d = 1'b0;
        idle_d = '0;
        if (state_q == ST_IDLE && pick_any) begin
            grant_d = pick_grant;
            sel_d = pick_idx;
            state_d = HEADER_EN ? ST_HDR : ST_DATA;
            if (HEADER_EN) begin
                tx_valid_d = 1'b1;
                tx_data_d = hdr_byte(HEADER_BASE, 3'(pick_idx));
            end
        end
        if (state_q == ST_HDR && tx_valid_q && bus.tx_ready)
            state_d = ST_DATA;
        if (state_q == ST_DATA) begin
            if (accept) begin
                tx_valid_d = 1'b1;
                tx_data_d = req_byte;
                state_d = bus.req_last[sel_q] ? ST_DRAIN : ST_DATA;
            end else if (!own_valid) begin
                idle_d = (idle_q == CMAX) ? idle_q : idle_q + CW'(1);
                if (LOCK_TIMEOUT != 0 && idle_d == CMAX) begin
                    timeout_d = 1'b1;
                    state_d = ST_DRAIN;
                end
            end else
                idle_d = idle_q;
        end
        if (state_q == ST_DRAIN && (!tx_valid_q || bus.tx_ready)) begin
            state_d = ST_IDLE;
            grant_d = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q <= IW'(N_REQ - 1);
            tx_data_q <= '0;
            tx_valid_q <= 1'b0;
            timeout_q <= 1'b0;
            idle_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q <= sel_d;
            tx_data_q <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            timeout_q <= timeout_d;
            idle_q <= idle_d;
        end
    end
    assign bus.req_ready = req_ready;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.grant = grant_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors for header/no-header arbiters, stalls, lock timeout and reset
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    uart_tx_arbiter_if #(.N_REQ(4)) m();
    uart_tx_arbiter_if #(.N_REQ(4)) n();
    uart_tx_arbiter #(.N_REQ(4), .HEADER_EN(1'b1), .HEADER_BASE(8'hF0), .LOCK_TIMEOUT(16))
        dut (.clk(clk), .rst_n(rst_n), .bus(m.slave));
    uart_tx_arbiter #(.N_REQ(4), .HEADER_EN(1'b0), .HEADER_BASE(8'hF0), .LOCK_TIMEOUT(4096))
        dut_nh (.clk(clk), .rst_n(rst_n), .bus(n.slave));
    typedef struct { int t; logic [7:0] b; } vec_t;
    vec_t vecs[$];
    int tests = 0, fails = 0, cyc = 0, tmo_n = 0, tmo_cyc = 0;
    int last_fire[4];
    int head[4], tail[4];
    logic [8:0] pb[4][32];
    logic [7:0] rx[$];
    logic stall_v = 1'b0;
    logic [7:0] stall_d;
    logic [3:0] gnt_seen, post_gnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input int t, input logic [7:0] b);
        vecs.push_back('{t, b});
    endtask

    task automatic drive();
        logic [3:0] v, l;
        logic [31:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < 4; i++)
            if (head[i] < tail[i]) begin
                v[i] = 1'b1;
                l[i] = pb[i][head[i]][8];
                d[8*i +: 8] = pb[i][head[i]][7:0];
            end
        m.req_valid = v;
        m.req_last = l;
        m.req_data = d;
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic last);
        pb[r][tail[r]] = {last, b};
        tail[r]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
        rx.delete();
        stall_v = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_q();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // one cycle: sample at negedge, advance requester queues just after posedge
    task automatic tick();
        logic [3:0] fire;
        @(negedge clk);
        cyc++;
        fire = m.req_valid & m.req_ready;
        for (int i = 0; i < 4; i++) if (fire[i]) last_fire[i] = cyc;
        if (m.timeout) begin tmo_n++; tmo_cyc = cyc; end
        if (stall_v) begin
            chk("tx_hold_valid", 32'(m.tx_valid), 1);
            chk("tx_hold_data", 32'(m.tx_data), 32'(stall_d));
        end
        if (m.tx_valid && !m.tx_ready) chk("skid_ready_low", 32'(m.req_ready), 0);
        stall_v = m.tx_valid & ~m.tx_ready;
        stall_d = m.tx_data;
        if (m.tx_valid && m.tx_ready) rx.push_back(m.tx_data);
        gnt_seen |= m.grant;
        if (tmo_n > 0 && cyc > tmo_cyc && post_gnt == 0 && m.grant != 0) post_gnt = m.grant;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (fire[i]) head[i]++;
        drive();
    endtask

    task automatic wait_done(input int t, input int cnt, input int budget);
        int k, pos;
        k = 0;
        while (rx.size() < cnt && k < budget) begin tick(); k++; end
        repeat (4) tick();
        chk($sformatf("t%0d_rx_count", t), rx.size(), cnt);
        pos = 0;
        foreach (vecs[i])
            if (vecs[i].t == t) begin
                chk($sformatf("t%0d_byte%0d", t, pos), pos < rx.size() ? 32'(rx[pos]) : 32'h100, 32'(vecs[i].b));
                pos++;
            end
        chk($sformatf("t%0d_grant_idle", t), 32'(m.grant), 0);
    endtask

    initial begin
        int k;
        add(1, 8'hF0); add(1, 8'h41); add(1, 8'h42); add(1, 8'h43);
        for (int i = 0; i < 4; i++) begin add(2, 8'hF0 | 8'(i)); add(2, 8'hA0 | 8'(i)); add(2, 8'hB0 | 8'(i)); end
        add(3, 8'hF1); add(3, 8'hC1); add(3, 8'hC2); add(3, 8'hC3); add(3, 8'hC4);
        add(4, 8'hF1); add(4, 8'hD1); add(4, 8'hF2); add(4, 8'hE1);
        add(6, 8'hF0); add(6, 8'h61); add(6, 8'hF3); add(6, 8'h71);
        m.tx_ready = 1'b1;
        n.tx_ready = 1'b1; n.req_valid = '0; n.req_last = '0; n.req_data = '0;
        gnt_seen = '0; post_gnt = '0;
        clear_q();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(m.grant), 0);
        chk("rst_tx_valid", 32'(m.tx_valid), 0);
        chk("rst_tx_data", 32'(m.tx_data), 0);
        chk("rst_req_ready", 32'(m.req_ready), 0);
        chk("rst_timeout", 32'(m.timeout), 0);
        chk("rst_nh_tx_valid", 32'(n.tx_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // 1: single requester packet with header
        push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1); drive();
        wait_done(1, 4, 40);
        chk("t1_grant_seen", 32'(gnt_seen), 32'h1);
        // 2: all four contend after reset, strict rotation from 0
        do_reset();
        gnt_seen = '0;
        for (int i = 0; i < 4; i++) begin push(i, 8'hA0 | 8'(i), 0); push(i, 8'hB0 | 8'(i), 1); end
        drive();
        wait_done(2, 12, 100);
        chk("t2_grant_seen", 32'(gnt_seen), 32'hF);
        // 3: TX stall mid-packet
        rx.delete();
        push(1, 8'hC1, 0); push(1, 8'hC2, 0); push(1, 8'hC3, 0); push(1, 8'hC4, 1); drive();
        k = 0;
        while (rx.size() < 2 && k < 20) begin tick(); k++; end
        m.tx_ready = 1'b0;
        repeat (20) tick();
        chk("t3_stall_rx", rx.size(), 2);
        m.tx_ready = 1'b1;
        wait_done(3, 5, 40);
        // 4: owner stalls, lock times out, waiting requester 2 follows
        rx.delete();
        tmo_n = 0; post_gnt = '0;
        push(1, 8'hD1, 0); drive();
        k = 0;
        while (m.grant != 4'b0010 && k < 10) begin tick(); k++; end
        chk("t4_grant_r1", 32'(m.grant), 32'h2);
        push(2, 8'hE1, 1); drive();
        k = 0;
        while (tmo_n == 0 && k < 60) begin tick(); k++; end
        chk("t4_tmo_delay", tmo_cyc - last_fire[1], 17);
        wait_done(4, 4, 40);
        chk("t4_next_grant", 32'(post_gnt), 32'h4);
        chk("t4_tmo_pulses", tmo_n, 1);
        // 5: no-header latency on the second instance
        @(posedge clk); #1;
        n.req_valid = 4'b0100; n.req_last = 4'b0100; n.req_data = 32'h0077_0000;
        @(negedge clk);
        chk("t5_k_grant", 32'(n.grant), 0);
        chk("t5_k_tx_valid", 32'(n.tx_valid), 0);
        @(negedge clk);
        chk("t5_k1_grant", 32'(n.grant), 32'h4);
        chk("t5_k1_ready", 32'(n.req_ready), 32'h4);
        chk("t5_k1_tx_valid", 32'(n.tx_valid), 0);
        @(posedge clk); #1;
        n.req_valid = '0; n.req_last = '0; n.req_data = '0;
        @(negedge clk);
        chk("t5_k2_tx_valid", 32'(n.tx_valid), 1);
        chk("t5_k2_tx_data", 32'(n.tx_data), 32'h77);
        @(negedge clk);
        chk("t5_k3_tx_valid", 32'(n.tx_valid), 0);
        chk("t5_k3_grant", 32'(n.grant), 0);
        // 6: asynchronous reset mid-packet, then 0 beats 3
        rx.delete();
        push(0, 8'h51, 0); push(0, 8'h52, 0); push(0, 8'h53, 1); drive();
        k = 0;
        while (rx.size() < 2 && k < 20) begin tick(); k++; end
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(m.grant), 0);
        chk("t6_rst_tx_valid", 32'(m.tx_valid), 0);
        chk("t6_rst_tx_data", 32'(m.tx_data), 0);
        chk("t6_rst_req_ready", 32'(m.req_ready), 0);
        chk("t6_rst_timeout", 32'(m.timeout), 0);
        clear_q();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push(0, 8'h61, 1); push(3, 8'h71, 1); drive();
        wait_done(6, 4, 40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
